clk_pair_gen: RTL and testbench
===============================

Name: clk_pair_gen

Overview:
- Generates two programmable divided clocks, clk1_out and clk2_out, from one system clock.
- Its outputs feed the clock-speed comparator as its clk1/clk2 stimulus pair.
- Divisors reload at runtime through a load/ack handshake. New values take effect only at a period boundary, so no period is ever truncated.
- Also outputs l2h_exp: the l2h value the comparator must report for the active divisor pair.

Parameters:
- DIV_W, 16, width of the divisor and counter registers.
- DEFAULT_DIV1, 4, clk1_out divisor after reset (must be ≥2).
- DEFAULT_DIV2, 6, clk2_out divisor after reset (must be ≥2).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  1 = run both dividers; 0 = hold both outputs low.
- div_load  input  1  request to load div1_in/div2_in; accepted only when busy=0.
- div1_in  input  DIV_W  new clk1_out divisor.
- div2_in  input  DIV_W  new clk2_out divisor.
- busy  output  1  a load is pending and not yet applied to both channels.
- div_ack  output  1  one-cycle pulse: both new divisors are now active.
- clk1_out  output  1  divided clock, channel 1.
- clk2_out  output  1  divided clock, channel 2.
- l2h_exp  output  1  1 when div1_cur ≥ div2_cur (freq1 ≤ freq2), else 0.

Behaviour:
- All outputs are registered.
- Per-channel state (x = 1, 2): cnt_x, div_x_cur, div_x_pend, pend_x; H_x = div_x_cur >> 1.
- Reset (async):
  - div_x_cur = DEFAULT_DIVx; cnt_x = DEFAULT_DIVx − 1.
  - pend_x = 0; busy = 0; div_ack = 0; clkx_out = 0.
  - l2h_exp = (DEFAULT_DIV1 ≥ DEFAULT_DIV2); 0 with the defaults.
  - Reset mid-load discards the pending load.
- Counting, en=1, each edge:
  - If cnt_x == div_x_cur − 1, the channel wraps: cnt_x ← 0. If pend_x is set, div_x_cur ← div_x_pend and pend_x ← 0.
  - Otherwise cnt_x ← cnt_x + 1.
  - clkx_out ← (cnt_x_next < H_x_next), using post-update values.
  - Result: each period is exactly N clk cycles, high for N>>1 cycles then low for the remaining N − (N>>1). Odd N gives a longer low phase.
- First edge with en=1 after reset or re-enable starts a fresh period: cnt=0, output high.
- en=0, each edge:
  - clkx_out ← 0.
  - If pend_x is set: div_x_cur ← div_x_pend and pend_x ← 0 at that edge.
  - cnt_x ← div_x_cur_next − 1.
- Load handshake:
  - Accept when div_load=1 and busy=0. On that edge: div_x_pend ← max(div_x_in, 2), pend1 = pend2 = 1, busy ← 1.
  - div_load while busy=1 is ignored, with no queuing.
  - A load accepted on the same edge as a wrap is not applied on that edge; it waits for the next wrap.
- Completion:
  - On any edge where busy=1 and pend1 = pend2 = 0: busy ← 0 and div_ack ← 1.
  - div_ack is 0 on all other edges.
  - The earliest new load is accepted on the edge after div_ack.
- l2h_exp ← (div1_cur ≥ div2_cur) every edge. It lags any change of div_x_cur by one cycle.
- Width/clamp rules:
  - Divisor inputs 0 and 1 are treated as 2.
  - The maximum divisor is 2^DIV_W − 1.
  - The counter never exceeds div − 1; no wrap-around beyond that.
- The two channels are independent; their wraps may coincide.

Test Plan:
- Reset release, en=1, defaults 4/6 → clk1_out repeats 1,1,0,0 and clk2_out repeats 1,1,1,0,0,0. Both are high on the first edge after en. l2h_exp = 0.
- Load div1_in=3, div2_in=2 mid-period → busy=1 the next cycle. Each channel finishes its current 4- or 6-cycle period, then runs 1,0,0 and 1,0 respectively. div_ack pulses once, one cycle after the later switch. busy=0 with it. l2h_exp → 1.
- div_load held high through busy with a second value pair (9/9) → second pair ignored. Only the first pair is applied; exactly one div_ack.
- Load div1_in=0, div2_in=1 → both channels run period 2 (1,0). l2h_exp = 1 (equal divisors).
- en=0 with a load pending → outputs 0. Pending values are applied on the next edge and div_ack pulses the following edge. Re-enable starts both outputs high with the new periods.
- Assert rst mid-period with a load pending → all outputs 0 and busy=0 immediately (async). After release, defaults 4/6 run and the discarded load never appears.

Source files
------------

// File: rtl/clk_pair_gen.sv
// Two programmable clock dividers whose outputs form a clk1/clk2 stimulus pair.
// New divisors arrive through a load/ack handshake. Each channel switches to
// its new divisor only at its own period boundary, so no period is cut short.
// l2h_exp tells the downstream comparator which answer to expect for the
// divisor pair that is currently active.

// One divider channel: counter, active divisor and a one-deep pending divisor.
module clk_pair_chan #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div_in,
    output logic             clk_out,
    output logic [DIV_W-1:0] div_cur,
    output logic             pend
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
    localparam logic [DIV_W-1:0] ZERO      = '0;

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] div_cur_next;
    logic [DIV_W-1:0] div_pend;
    logic [DIV_W-1:0] div_pend_next;
    logic             pend_next;
    logic             clk_out_next;
    logic             wrap;

    // A period ends when the counter has reached the last cycle of the divisor.
    always_comb begin
        wrap = (cnt == (div_cur - ONE));
    end

    // Next-state for counter, divisors and output level; swaps only at wraps or while idle.
    always_comb begin
        cnt_next      = cnt;
        div_cur_next  = div_cur;
        div_pend_next = div_pend;
        pend_next     = pend;
        if (en) begin
            if (wrap) begin
                cnt_next = ZERO;
                if (pend) begin
                    div_cur_next = div_pend;
                    pend_next    = 1'b0;
                end
            end else begin
                cnt_next = cnt + ONE;
            end
        end else begin
            if (pend) begin
                div_cur_next = div_pend;
                pend_next    = 1'b0;
            end
            cnt_next = div_cur_next - ONE;
        end
        if (load) begin
            div_pend_next = div_in;
            pend_next     = 1'b1;
        end
        clk_out_next = en && (cnt_next < (div_cur_next >> 1));
    end

    // Channel state register; parked at div-1 so the first enabled edge starts a period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= RESET_DIV - ONE;
            div_cur  <= RESET_DIV;
            div_pend <= RESET_DIV;
            pend     <= 1'b0;
            clk_out  <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            div_cur  <= div_cur_next;
            div_pend <= div_pend_next;
            pend     <= pend_next;
            clk_out  <= clk_out_next;
        end
    end

endmodule

// Top level: handshake FSM, input clamping and the two channels.
module clk_pair_gen #(
    parameter int DIV_W        = 16,
    parameter int DEFAULT_DIV1 = 4,
    parameter int DEFAULT_DIV2 = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div1_in,
    input  logic [DIV_W-1:0] div2_in,
    output logic             busy,
    output logic             div_ack,
    output logic             clk1_out,
    output logic             clk2_out,
    output logic             l2h_exp
);

    typedef enum logic {
        LOAD_IDLE,
        LOAD_WAIT
    } load_state_t;

    localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(2);
    localparam logic             L2H_RESET = (DEFAULT_DIV1 >= DEFAULT_DIV2);

    load_state_t      state;
    load_state_t      state_next;
    logic             div_ack_next;
    logic             accept;
    logic [DIV_W-1:0] div1_clamped;
    logic [DIV_W-1:0] div2_clamped;
    logic [DIV_W-1:0] div1_cur;
    logic [DIV_W-1:0] div2_cur;
    logic             pend1;
    logic             pend2;

    // Divisors below 2 cannot form a high and a low phase, so they are raised to 2.
    always_comb begin
        div1_clamped = (div1_in < MIN_DIV) ? MIN_DIV : div1_in;
        div2_clamped = (div2_in < MIN_DIV) ? MIN_DIV : div2_in;
    end

    // Handshake state register; div_ack is registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOAD_IDLE;
            div_ack <= 1'b0;
        end else begin
            state   <= state_next;
            div_ack <= div_ack_next;
        end
    end

    // Leave WAIT once both channels have consumed their pending divisor.
    always_comb begin
        state_next   = state;
        div_ack_next = 1'b0;
        case (state)
            LOAD_IDLE: begin
                if (div_load) begin
                    state_next = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (!pend1 && !pend2) begin
                    state_next   = LOAD_IDLE;
                    div_ack_next = 1'b1;
                end
            end
            default: begin
                state_next = LOAD_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        busy   = (state == LOAD_WAIT);
        accept = div_load && (state == LOAD_IDLE);
    end

    clk_pair_chan #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV1)
    ) u_chan1 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (accept),
        .div_in  (div1_clamped),
        .clk_out (clk1_out),
        .div_cur (div1_cur),
        .pend    (pend1)
    );

    clk_pair_chan #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV2)
    ) u_chan2 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (accept),
        .div_in  (div2_clamped),
        .clk_out (clk2_out),
        .div_cur (div2_cur),
        .pend    (pend2)
    );

    // Expected comparator answer follows the active divisors one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l2h_exp <= L2H_RESET;
        end else begin
            l2h_exp <= (div1_cur >= div2_cur);
        end
    end

endmodule

// File: tb/tb_clk_pair_gen.sv
// Self-checking bench for clk_pair_gen. A period-based reference model pushes
// the expected output vector {clk1, clk2, busy, ack, l2h} for each driven
// cycle; each test task pops it after the edge and compares inline.
module tb_clk_pair_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic        div_load;
    logic [15:0] div1_in;
    logic [15:0] div2_in;
    logic        busy;
    logic        div_ack;
    logic        clk1_out;
    logic        clk2_out;
    logic        l2h_exp;

    int checks = 0;
    int fails  = 0;

    logic [4:0] sb[$];

    bit q1[$];
    bit q2[$];
    int m_div1;
    int m_div2;
    int m_pv1;
    int m_pv2;
    bit m_pend1;
    bit m_pend2;
    bit m_busy;
    bit m_ack;
    bit m_l2h;
    bit m_out1;
    bit m_out2;

    clk_pair_gen #(
        .DIV_W        (16),
        .DEFAULT_DIV1 (4),
        .DEFAULT_DIV2 (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_load (div_load),
        .div1_in  (div1_in),
        .div2_in  (div2_in),
        .busy     (busy),
        .div_ack  (div_ack),
        .clk1_out (clk1_out),
        .clk2_out (clk2_out),
        .l2h_exp  (l2h_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        q1.delete();
        q2.delete();
        m_div1  = 4;
        m_div2  = 6;
        m_pv1   = 0;
        m_pv2   = 0;
        m_pend1 = 1'b0;
        m_pend2 = 1'b0;
        m_busy  = 1'b0;
        m_ack   = 1'b0;
        m_l2h   = 1'b0;
        m_out1  = 1'b0;
        m_out2  = 1'b0;
    endtask

    // Reference: a period is a queued list of bits; when empty, a new period begins.
    task automatic model_step(input logic e, input logic ld, input logic [15:0] d1, input logic [15:0] d2);
        bit acc;
        bit ackn;
        acc   = ld && !m_busy;
        ackn  = m_busy && !m_pend1 && !m_pend2;
        m_l2h = (m_div1 >= m_div2);
        if (e) begin
            if (q1.size() == 0) begin
                if (m_pend1) begin
                    m_div1  = m_pv1;
                    m_pend1 = 1'b0;
                end
                for (int i = 0; i < m_div1; i++) q1.push_back(i < (m_div1 / 2));
            end
            m_out1 = q1.pop_front();
            if (q2.size() == 0) begin
                if (m_pend2) begin
                    m_div2  = m_pv2;
                    m_pend2 = 1'b0;
                end
                for (int i = 0; i < m_div2; i++) q2.push_back(i < (m_div2 / 2));
            end
            m_out2 = q2.pop_front();
        end else begin
            m_out1 = 1'b0;
            m_out2 = 1'b0;
            if (m_pend1) begin
                m_div1  = m_pv1;
                m_pend1 = 1'b0;
            end
            if (m_pend2) begin
                m_div2  = m_pv2;
                m_pend2 = 1'b0;
            end
            q1.delete();
            q2.delete();
        end
        if (acc) begin
            m_pv1   = (int'(d1) < 2) ? 2 : int'(d1);
            m_pv2   = (int'(d2) < 2) ? 2 : int'(d2);
            m_pend1 = 1'b1;
            m_pend2 = 1'b1;
            m_busy  = 1'b1;
        end
        if (ackn) m_busy = 1'b0;
        m_ack = ackn;
    endtask

    task automatic applyStimulus(input logic e, input logic ld, input logic [15:0] d1, input logic [15:0] d2);
        en       = e;
        div_load = ld;
        div1_in  = d1;
        div2_in  = d2;
        model_step(e, ld, d1, d2);
        sb.push_back({m_out1, m_out2, m_busy, m_ack, m_l2h});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        logic [4:0] exp_v;
        rst      = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div1_in  = '0;
        div2_in  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        obs = {clk1_out, clk2_out, busy, div_ack, l2h_exp};
        checks++;
        if (obs !== 5'b00000) begin
            fails++;
            $display("[TB] FAIL reset_state: got %b required %b", obs, 5'b00000);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b0, 16'd0, 16'd0);
            exp_v = sb.pop_front();
            obs   = {clk1_out, clk2_out, busy, div_ack, l2h_exp};
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("[TB] FAIL reset_idle c%0d: got %b required %b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_defaults();
        logic [4:0] obs;
        logic [4:0] exp_v;
        for (int c = 0; c < 24; c++) begin
            applyStimulus(1'b1, 1'b0, 16'd0, 16'd0);
            exp_v = sb.pop_front();
            obs   = {clk1_out, clk2_out, busy, div_ack, l2h_exp};
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("[TB] FAIL defaults c%0d: got %b required %b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_load_mid();
        logic [4:0] obs;
        logic [4:0] exp_v;
        int acks = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 1) applyStimulus(1'b1, 1'b1, 16'd3, 16'd2);
            else        applyStimulus(1'b1, 1'b0, 16'd0, 16'd0);
            exp_v = sb.pop_front();
            obs   = {clk1_out, clk2_out, busy, div_ack, l2h_exp};
            acks += int'(div_ack);
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("[TB] FAIL load_mid c%0d: got %b required %b", c, obs, exp_v);
            end
        end
        checks++;
        if (acks !== 1) begin
            fails++;
            $display("[TB] FAIL load_mid_acks: got %0d required 1", acks);
        end
        checks++;
        if (l2h_exp !== 1'b1) begin
            fails++;
            $display("[TB] FAIL load_mid_l2h: got %b required 1", l2h_exp);
        end
    endtask

    task automatic test_load_held();
        logic [4:0] obs;
        logic [4:0] exp_v;
        int acks = 0;
        bit holding = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c == 0) begin
                applyStimulus(1'b1, 1'b1, 16'd5, 16'd7);
            end else if (holding && m_busy) begin
                applyStimulus(1'b1, 1'b1, 16'd9, 16'd9);
            end else begin
                holding = 1'b0;
                applyStimulus(1'b1, 1'b0, 16'd0, 16'd0);
            end
            exp_v = sb.pop_front();
            obs   = {clk1_out, clk2_out, busy, div_ack, l2h_exp};
            acks += int'(div_ack);
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("[TB] FAIL load_held c%0d: got %b required %b", c, obs, exp_v);
            end
        end
        checks++;
        if (acks !== 1) begin
            fails++;
            $display("[TB] FAIL load_held_acks: got %0d required 1", acks);
        end
    endtask

    task automatic test_clamp();
        logic [4:0] obs;
        logic [4:0] exp_v;
        int acks = 0;
        for (int c = 0; c < 24; c++) begin
            if (c == 0) applyStimulus(1'b1, 1'b1, 16'd0, 16'd1);
            else        applyStimulus(1'b1, 1'b0, 16'd0, 16'd0);
            exp_v = sb.pop_front();
            obs   = {clk1_out, clk2_out, busy, div_ack, l2h_exp};
            acks += int'(div_ack);
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("[TB] FAIL clamp c%0d: got %b required %b", c, obs, exp_v);
            end
        end
        checks++;
        if (acks !== 1) begin
            fails++;
            $display("[TB] FAIL clamp_acks: got %0d required 1", acks);
        end
        checks++;
        if (l2h_exp !== 1'b1) begin
            fails++;
            $display("[TB] FAIL clamp_l2h: got %b required 1", l2h_exp);
        end
    endtask

    task automatic test_enable_off_load();
        logic [4:0] obs;
        logic [4:0] exp_v;
        for (int c = 0; c < 24; c++) begin
            if (c == 0)     applyStimulus(1'b1, 1'b1, 16'd6, 16'd3);
            else if (c < 5) applyStimulus(1'b0, 1'b0, 16'd0, 16'd0);
            else            applyStimulus(1'b1, 1'b0, 16'd0, 16'd0);
            exp_v = sb.pop_front();
            obs   = {clk1_out, clk2_out, busy, div_ack, l2h_exp};
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("[TB] FAIL en_off c%0d: got %b required %b", c, obs, exp_v);
            end
            if (c == 5) begin
                checks++;
                if ({clk1_out, clk2_out} !== 2'b11) begin
                    fails++;
                    $display("[TB] FAIL reenable_high: got %b required 11", {clk1_out, clk2_out});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] obs;
        logic [4:0] exp_v;
        int acks = 0;
        applyStimulus(1'b1, 1'b0, 16'd0, 16'd0);
        void'(sb.pop_front());
        applyStimulus(1'b1, 1'b1, 16'd7, 16'd8);
        exp_v = sb.pop_front();
        obs   = {clk1_out, clk2_out, busy, div_ack, l2h_exp};
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("[TB] FAIL reset_mid_load: got %b required %b", obs, exp_v);
        end
        #2;
        rst = 1'b1;
        #1;
        obs = {clk1_out, clk2_out, busy, div_ack, l2h_exp};
        checks++;
        if (obs !== 5'b00000) begin
            fails++;
            $display("[TB] FAIL reset_async: got %b required %b", obs, 5'b00000);
        end
        model_reset();
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 36; c++) begin
            applyStimulus(1'b1, 1'b0, 16'd0, 16'd0);
            exp_v = sb.pop_front();
            obs   = {clk1_out, clk2_out, busy, div_ack, l2h_exp};
            acks += int'(div_ack);
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("[TB] FAIL reset_mid c%0d: got %b required %b", c, obs, exp_v);
            end
        end
        checks++;
        if (acks !== 0) begin
            fails++;
            $display("[TB] FAIL reset_mid_acks: got %0d required 0", acks);
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_load_mid();
        test_load_held();
        test_clamp();
        test_enable_off_load();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
